exception_ctrl: RTL
===================

// Module: exception_ctrl
// PURPOSE
//  Upstream of cp0: collects MEM-stage exception flags, eret and interrupt requests, picks one by MIPS
//  priority and drives cp0 (exception, cp0_exception_code, pc, eret). Then flushes the pipeline for a
//  fixed number of cycles and hands the fetch stage a redirect PC (exception vector, or EPC for eret).
// PARAMETERS
//  EXC_VECTOR    32'hBFC0_0380  general exception entry address
//  FLUSH_CYCLES  2              cycles flush is held after an accepted event (1..15)
// PORTS
//  clk               in   1   single clock; all state on posedge
//  rst               in   1   synchronous, active-high reset
//  enable            in   1   0 = pipeline stalled: all state frozen, no event accepted
//  mem_valid         in   1   MEM stage holds a real instruction
//  mem_pc            in   32  PC of the MEM instruction
//  mem_in_ds         in   1   MEM instruction is in a branch delay slot
//  exc_adel_if       in   1   fetch address error
//  exc_ri, exc_ov    in   1   reserved instruction / overflow
//  exc_sys, exc_bp   in   1   syscall / break
//  exc_adel_ld       in   1   load address error
//  exc_ades          in   1   store address error
//  eret_req          in   1   MEM instruction is eret
//  hw_int            in   6   asynchronous hardware interrupt lines
//  status_ie         in   1   Status.IE
//  status_exl        in   1   Status.EXL
//  status_im         in   8   Status.IM[7:0]
//  cause_ip_sw       in   2   Cause.IP[1:0]
//  T1                in   1   timer interrupt from cp0 (Cause[30])
//  recover_pc        in   32  EPC from cp0
//  cp0_exception     out  1   one-cycle pulse to cp0
//  cp0_exception_code out 5   ExcCode, valid with cp0_exception
//  cp0_pc            out  32  EPC value for cp0, valid with cp0_exception
//  cp0_eret          out  1   one-cycle pulse to cp0
//  flush             out  1   kill IF..MEM
//  redirect_valid    out  1   redirect_pc valid; held until redirect_ready
//  redirect_pc       out  32  new fetch PC
//  redirect_ready    in   1   fetch stage accepts redirect
//  busy              out  1   FSM not IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE, counter=0, sync flops=0, every output 0.
//  - Interrupt path: hw_int through 2-flop sync; pending = {hw_s[5]|T1, hw_s[4:0], cause_ip_sw} & status_im;
//    int_take = status_ie & ~status_exl & |pending & mem_valid.
//  - Priority (high->low): Int(0), AdEL-IF(4), RI(10), Ov(12), Sys(8), Bp(9), AdEL-ld(4), AdES(5), eret.
//    Any exception beats a simultaneous eret_req; eret then ignored.
//  - All event inputs qualified by mem_valid & enable & state==IDLE; events in other states are dropped
//    (the instruction is being flushed).
//  - FSM IDLE -> FLUSH on accepted event at cycle N. Cycle N+1: cp0_exception or cp0_eret pulses once;
//    code and cp0_pc registered; flush=1 for cycles N+1..N+FLUSH_CYCLES.
//  - cp0_pc = mem_pc - 4 if mem_in_ds else mem_pc (32-bit wrap, no overflow check).
//  - FLUSH -> REDIRECT when counter hits FLUSH_CYCLES. REDIRECT: redirect_valid=1;
//    redirect_pc = EXC_VECTOR (exception) or recover_pc sampled on REDIRECT entry (eret).
//    Leave to IDLE on the cycle redirect_valid & redirect_ready; same-cycle new event not accepted.
//  - enable=0 in any state: FSM, counter and redirect_pc frozen; pulses not re-issued; flush/redirect_valid held.
//  - rst mid-FLUSH/REDIRECT: back to IDLE next edge, no pulse, no redirect.
// STRUCTURE
//  - Shared package: ExcCode constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV),
//    FSM state encoding (IDLE/FLUSH/REDIRECT), default EXC_VECTOR.
//  - One sub-module: int_sync (2-flop synchronizer + pending mask, outputs int_pending).
//  - Top: priority encoder, FSM, 4-bit flush counter, output registers.
// TESTING
//  - exc_ov=1, mem_pc=32'h8000_1000, in_ds=0 -> next cycle cp0_exception=1, code=12, cp0_pc=32'h8000_1000;
//    flush 2 cycles; redirect_pc=32'hBFC0_0380.
//  - exc_sys, in_ds=1, mem_pc=32'h8000_2004 -> code=8, cp0_pc=32'h8000_2000.
//  - exc_adel_if & exc_ri & eret_req together -> code=4, cp0_eret never pulses.
//  - eret_req, recover_pc=32'h8000_3000 -> cp0_eret pulse, redirect_pc=32'h8000_3000; redirect_ready low
//    3 cycles -> redirect_valid held 4 cycles, then IDLE.
//  - hw_int[2]=1, im[4]=1, ie=1, exl=0 -> code=0 after 2-cycle sync; same with exl=1 -> no event.
//  - rst asserted in FLUSH -> next cycle busy=0, flush=0, redirect_valid=0; enable=0 in REDIRECT freezes outputs.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the exception controller:
// MIPS ExcCodes, FSM encoding and default vector.
package exception_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

endpackage

// File: rtl/exception_ctrl_int_sync.sv
// Two-flop synchronizer for the hardware interrupt lines
// and Status.IM masking of all pending sources.
module exception_ctrl_int_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hw_int,
  input  logic       t1,
  input  logic [1:0] cause_ip_sw,
  input  logic [7:0] status_im,
  output logic [7:0] int_pending
);

  logic [5:0] hw_m;
  logic [5:0] hw_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      hw_m <= '0;
      hw_s <= '0;
    end else begin
      hw_m <= hw_int;
      hw_s <= hw_m;
    end
  end

  // timer shares the IP7 slot with hw line 5
  assign int_pending = {hw_s[5] | t1,
                        hw_s[4:0],
                        cause_ip_sw} & status_im;

endmodule

// File: rtl/exception_ctrl.sv
// Picks one MEM-stage event by MIPS priority, pulses cp0,
// flushes the pipe and hands fetch a redirect PC.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_ds,
  input  logic        exc_adel_if,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_adel_ld,
  input  logic        exc_ades,
  input  logic        eret_req,
  input  logic [5:0]  hw_int,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [1:0]  cause_ip_sw,
  input  logic        T1,
  input  logic [31:0] recover_pc,
  output logic        cp0_exception,
  output logic [4:0]  cp0_exception_code,
  output logic [31:0] cp0_pc,
  output logic        cp0_eret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  localparam logic [3:0] FL = 4'(FLUSH_CYCLES);

  state_e      state;
  state_e      state_nx;
  logic [3:0]  cnt;
  logic        eret_q;
  logic [7:0]  int_pending;
  logic        int_take;
  logic        exc_any;
  logic        is_exc;
  logic        accept;
  logic [4:0]  code_nx;
  logic [31:0] epc_nx;

  exception_ctrl_int_sync u_int_sync (
    .clk         (clk),
    .rst         (rst),
    .hw_int      (hw_int),
    .t1          (T1),
    .cause_ip_sw (cause_ip_sw),
    .status_im   (status_im),
    .int_pending (int_pending)
  );

  assign int_take = status_ie & ~status_exl
                  & (|int_pending) & mem_valid;
  assign exc_any  = exc_adel_if | exc_ri | exc_ov
                  | exc_sys | exc_bp
                  | exc_adel_ld | exc_ades;
  assign is_exc   = int_take | exc_any;
  assign accept   = enable & mem_valid
                  & (state == IDLE)
                  & (is_exc | eret_req);
  assign epc_nx   = mem_in_ds ? mem_pc - 32'd4 : mem_pc;

  always_comb begin
    code_nx = EXC_ADES;
    if (int_take)         code_nx = EXC_INT;
    else if (exc_adel_if) code_nx = EXC_ADEL;
    else if (exc_ri)      code_nx = EXC_RI;
    else if (exc_ov)      code_nx = EXC_OV;
    else if (exc_sys)     code_nx = EXC_SYS;
    else if (exc_bp)      code_nx = EXC_BP;
    else if (exc_adel_ld) code_nx = EXC_ADEL;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (enable) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept) state_nx = FLUSH;
      FLUSH:    if (cnt == FL) state_nx = REDIRECT;
      REDIRECT: if (redirect_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    flush          = (state == FLUSH);
    redirect_valid = (state == REDIRECT);
    busy           = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cp0_exception      <= 1'b0;
      cp0_eret           <= 1'b0;
      cp0_exception_code <= '0;
      cp0_pc             <= '0;
      redirect_pc        <= '0;
      eret_q             <= 1'b0;
      cnt                <= '0;
    end else begin
      cp0_exception <= accept & is_exc;
      cp0_eret      <= accept & ~is_exc;
      if (accept) begin
        cp0_exception_code <= code_nx;
        cp0_pc             <= epc_nx;
        eret_q             <= ~is_exc;
        cnt                <= 4'd1;
      end else if (enable && state == FLUSH) begin
        // EPC is sampled as the FSM enters REDIRECT
        if (cnt == FL)
          redirect_pc <= eret_q ? recover_pc
                                : EXC_VECTOR;
        else
          cnt <= cnt + 4'd1;
      end
    end
  end

endmodule
